// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and selects the next PC from sequential,
// branch, jump, jump-register and exception sources. Redirects that arrive while
// the pipeline is stalled are held until the stall releases.
`default_nettype none

module pc_sequencer #(
  parameter int unsigned      PC_W         = 13,
  parameter logic [PC_W-1:0]  RESET_VECTOR = 13'h0000,
  parameter logic [PC_W-1:0]  EXC_VECTOR   = 13'h1F00
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [PC_W-1:0] pc_plus1,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            jump_reg,
  input  logic [PC_W-1:0] jr_target,
  input  logic            exception,
  output logic [PC_W-1:0] pc_out,
  output logic            flush,
  output logic            redirect_pending,
  output logic [15:0]     fetch_count
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [PC_W-1:0] pend_target, pend_next;
  logic [15:0]     fetch_cnt, fetch_next;
  logic            flush_reg, flush_next;

  logic            redirect;
  logic [PC_W-1:0] sel_target;

  assign redirect = exception | jump_reg | branch_taken | jump;

  // Fixed priority: exception > jump_reg > branch_taken > jump.
  always_comb begin
    sel_target = jump_target;
    if (exception)         sel_target = EXC_VECTOR;
    else if (jump_reg)     sel_target = jr_target;
    else if (branch_taken) sel_target = branch_target;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      pc_reg      <= RESET_VECTOR;
      pend_target <= '0;
      fetch_cnt   <= '0;
      flush_reg   <= 1'b0;
    end else begin
      state       <= state_next;
      pc_reg      <= pc_next;
      pend_target <= pend_next;
      fetch_cnt   <= fetch_next;
      flush_reg   <= flush_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc_reg;
    pend_next  = pend_target;
    fetch_next = fetch_cnt;
    flush_next = 1'b0;
    case (state)
      RUN: begin
        if (redirect) begin
          if (stall) begin
            pend_next  = sel_target;
            state_next = HOLD;
          end else begin
            pc_next    = sel_target;
            flush_next = 1'b1;
          end
        end else if (!stall) begin
          pc_next    = pc_plus1;
          fetch_next = fetch_cnt + 16'd1;
        end
      end
      HOLD: begin
        // The held redirect is architecturally older; only an exception can displace it.
        if (exception) pend_next = EXC_VECTOR;
        if (!stall) begin
          pc_next    = exception ? EXC_VECTOR : pend_target;
          flush_next = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign pc_out           = pc_reg;
  assign flush            = flush_reg;
  assign redirect_pending = (state == HOLD);
  assign fetch_count      = fetch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared against a behavioural model of the PC selection rules.
`default_nettype none

module tb_pc_sequencer;

  localparam int PC_W = 13;
  localparam logic [PC_W-1:0] EXC = 13'h1F00;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [PC_W-1:0] pc_plus1 = '0;
  logic            stall = 1'b0;
  logic            branch_taken = 1'b0;
  logic [PC_W-1:0] branch_target = '0;
  logic            jump = 1'b0;
  logic [PC_W-1:0] jump_target = '0;
  logic            jump_reg = 1'b0;
  logic [PC_W-1:0] jr_target = '0;
  logic            exception = 1'b0;
  logic [PC_W-1:0] pc_out;
  logic            flush;
  logic            redirect_pending;
  logic [15:0]     fetch_count;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  logic [PC_W-1:0] m_pc;
  logic            m_pend_valid;
  logic [PC_W-1:0] m_pend;
  logic [15:0]     m_fc;
  logic            m_flush;

  pc_sequencer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pc_plus1         (pc_plus1),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .jump             (jump),
    .jump_target      (jump_target),
    .jump_reg         (jump_reg),
    .jr_target        (jr_target),
    .exception        (exception),
    .pc_out           (pc_out),
    .flush            (flush),
    .redirect_pending (redirect_pending),
    .fetch_count      (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = '0; m_pend_valid = 1'b0; m_pend = '0; m_fc = '0; m_flush = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, return at posedge+1.
  task automatic step(input logic s, input logic br, input logic [PC_W-1:0] bt,
                      input logic j, input logic [PC_W-1:0] jt,
                      input logic jr, input logic [PC_W-1:0] jrt, input logic ex);
    logic            any;
    logic [PC_W-1:0] tgt;
    stall = s; branch_taken = br; branch_target = bt; jump = j; jump_target = jt;
    jump_reg = jr; jr_target = jrt; exception = ex;
    pc_plus1 = m_pc + 13'd1;
    any = ex | jr | br | j;
    tgt = ex ? EXC : jr ? jrt : br ? bt : jt;
    @(posedge clk);
    #1;
    m_flush = 1'b0;
    if (m_pend_valid) begin
      if (ex) m_pend = EXC;
      if (!s) begin
        m_pc = m_pend; m_pend_valid = 1'b0; m_flush = 1'b1;
      end
    end else if (any) begin
      if (s) begin
        m_pend_valid = 1'b1; m_pend = tgt;
      end else begin
        m_pc = tgt; m_flush = 1'b1;
      end
    end else if (!s) begin
      m_pc = m_pc + 13'd1;
      m_fc = m_fc + 16'd1;
    end
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, 0, '0, 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    stall = 0; branch_taken = 0; jump = 0; jump_reg = 0; exception = 0;
    model_reset();
    #1;
    vectors++;
    if (pc_out !== 13'h0 || flush !== 1'b0 || redirect_pending !== 1'b0 || fetch_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: pc=%h flush=%b pend=%b fc=%h, expected 0000/0/0/0000",
               pc_out, flush, redirect_pending, fetch_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_sequential();
    test_reset();
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, '0, 0, '0, 0, '0, 0);
      vectors++;
      if (pc_out !== PC_W'(i) || flush !== 1'b0) begin
        errors++;
        $display("FAIL seq_pc%0d: pc=%h flush=%b, expected %h/0", i, pc_out, flush, PC_W'(i));
      end
    end
    vectors++;
    if (fetch_count !== 16'd4) begin
      errors++;
      $display("FAIL seq_fetch_count: got %0d expected 4", fetch_count);
    end
  endtask

  task automatic test_wrap();
    test_reset();
    step(0, 0, '0, 1, 13'h1FFF, 0, '0, 0);
    vectors++;
    if (pc_out !== 13'h1FFF || flush !== 1'b1 || fetch_count !== 16'd0) begin
      errors++;
      $display("FAIL wrap_setup: pc=%h flush=%b fc=%0d, expected 1fff/1/0", pc_out, flush, fetch_count);
    end
    step(0, 0, '0, 0, '0, 0, '0, 0);
    vectors++;
    if (pc_out !== 13'h0000 || fetch_count !== 16'd1 || flush !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pc: pc=%h fc=%0d flush=%b, expected 0000/1/0", pc_out, fetch_count, flush);
    end
  endtask

  task automatic test_branch_priority();
    test_reset();
    seq(5);
    step(0, 1, 13'h040, 1, 13'h080, 0, '0, 0);
    vectors++;
    if (pc_out !== 13'h040 || flush !== 1'b1) begin
      errors++;
      $display("FAIL branch_over_jump: pc=%h flush=%b, expected 0040/1", pc_out, flush);
    end
    step(0, 0, '0, 0, '0, 0, '0, 0);
    vectors++;
    if (pc_out !== 13'h041 || flush !== 1'b0 || fetch_count !== 16'd6) begin
      errors++;
      $display("FAIL branch_after: pc=%h flush=%b fc=%0d, expected 0041/0/6", pc_out, flush, fetch_count);
    end
    // exception beats jump_reg beats branch
    step(0, 1, 13'h011, 0, '0, 1, 13'h022, 0);
    vectors++;
    if (pc_out !== 13'h022) begin
      errors++;
      $display("FAIL jr_over_branch: pc=%h expected 0022", pc_out);
    end
    step(0, 1, 13'h011, 1, 13'h033, 1, 13'h022, 1);
    vectors++;
    if (pc_out !== EXC || flush !== 1'b1) begin
      errors++;
      $display("FAIL exc_over_all: pc=%h flush=%b expected 1f00/1", pc_out, flush);
    end
  endtask

  task automatic test_stall_redirect();
    test_reset();
    seq(7);
    step(1, 0, '0, 1, 13'h100, 0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step(1, 0, '0, 0, '0, 0, '0, 0);
      vectors++;
      if (pc_out !== 13'h007 || redirect_pending !== 1'b1 || flush !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: pc=%h pend=%b flush=%b, expected 0007/1/0",
                 i, pc_out, redirect_pending, flush);
      end
    end
    // a younger branch during HOLD must be ignored
    step(0, 1, 13'h055, 0, '0, 0, '0, 0);
    vectors++;
    if (pc_out !== 13'h100 || flush !== 1'b1 || redirect_pending !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: pc=%h flush=%b pend=%b, expected 0100/1/0",
               pc_out, flush, redirect_pending);
    end
    step(0, 0, '0, 0, '0, 0, '0, 0);
    vectors++;
    if (flush !== 1'b0 || pc_out !== 13'h101 || fetch_count !== 16'd8) begin
      errors++;
      $display("FAIL stall_after: pc=%h flush=%b fc=%0d, expected 0101/0/8", pc_out, flush, fetch_count);
    end
  endtask

  task automatic test_hold_exception();
    test_reset();
    step(1, 0, '0, 1, 13'h100, 0, '0, 0);
    step(1, 0, '0, 0, '0, 0, '0, 1);
    vectors++;
    if (redirect_pending !== 1'b1 || pc_out !== 13'h000) begin
      errors++;
      $display("FAIL hold_exc_pend: pc=%h pend=%b, expected 0000/1", pc_out, redirect_pending);
    end
    step(0, 0, '0, 0, '0, 0, '0, 0);
    vectors++;
    if (pc_out !== EXC || flush !== 1'b1) begin
      errors++;
      $display("FAIL hold_exc_release: pc=%h flush=%b, expected 1f00/1", pc_out, flush);
    end
  endtask

  task automatic test_async_reset();
    test_reset();
    seq(3);
    step(1, 0, '0, 1, 13'h100, 0, '0, 0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (pc_out !== 13'h000 || redirect_pending !== 1'b0 || fetch_count !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: pc=%h pend=%b fc=%0d, expected 0000/0/0",
               pc_out, redirect_pending, fetch_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seq(2);
    vectors++;
    if (pc_out !== 13'h002 || flush !== 1'b0 || fetch_count !== 16'd2) begin
      errors++;
      $display("FAIL async_resume: pc=%h flush=%b fc=%0d, expected 0002/0/2", pc_out, flush, fetch_count);
    end
  endtask

  task automatic test_random();
    test_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 3) == 0,
           ($urandom % 8) == 0, PC_W'($urandom),
           ($urandom % 8) == 0, PC_W'($urandom),
           ($urandom % 10) == 0, PC_W'($urandom),
           ($urandom % 16) == 0);
      vectors++;
      if (pc_out !== m_pc || flush !== m_flush || redirect_pending !== m_pend_valid || fetch_count !== m_fc) begin
        errors++;
        $display("FAIL random[%0d]: pc=%h flush=%b pend=%b fc=%h, expected %h/%b/%b/%h",
                 i, pc_out, flush, redirect_pending, fetch_count, m_pc, m_flush, m_pend_valid, m_fc);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_wrap();
    test_branch_priority();
    test_stall_redirect();
    test_hold_exception();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
